// File: rtl/lc3b_dm_cache_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_dm_cache_pkg
// Shared types and constants for the LC-3b direct-mapped cache.
//   - LC-3b memory-port typedefs (line, tag, index, offset, write mask)
//   - Cache-specific additions: FSM state enum, per-line byte mask, set count
//   - Helpers: CPU write mask -> line byte mask expansion, tag extraction
// -----------------------------------------------------------------------------
package lc3b_dm_cache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [9:0]   lc3b_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [2:0]   lc3b_c_offset;
  typedef logic [1:0]   lc3b_mem_wmask;

  // One bit per byte of a 128-bit line.
  typedef logic [15:0]  lc3b_c_byte_mask;

  localparam int CACHE_SETS = 8;
  localparam int CACHE_LINE_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WRITEBACK = 2'b01,
    FILL      = 2'b10
  } lc3b_cache_state;

  // Place the 2-bit word write mask at the byte position of the addressed word.
  function automatic lc3b_c_byte_mask expand_wmask(input lc3b_mem_wmask wmask,
                                                    input lc3b_c_offset  offset);
    lc3b_c_byte_mask mask;
    mask = '0;
    mask[{offset, 1'b0} +: 2] = wmask;
    return mask;
  endfunction

  // Tag is the upper 9 address bits, zero-extended to the 10-bit tag type.
  function automatic lc3b_tag tag_of(input lc3b_word addr);
    return {1'b0, addr[15:7]};
  endfunction

endpackage

// File: rtl/lc3b_dm_cache_control.sv
// -----------------------------------------------------------------------------
// lc3b_dm_cache_control
// Controller FSM for the direct-mapped write-back cache (IDLE/WRITEBACK/FILL).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mem_read/mem_write  CPU request (held until mem_resp)
//   hit                 addressed set is valid and tag matches
//   victim_dirty        addressed set is valid and dirty
//   pmem_resp           physical memory completion
//   mem_resp            one-cycle CPU completion (IDLE hit only)
//   pmem_read/write     line fill / write-back strobes, held until pmem_resp
//   cpu_write_en        merge CPU write into the addressed line this edge
//   fill_en             load pmem_rdata, tag, valid=1, dirty=0 this edge
//   clean_en            clear dirty after a completed write-back
//   hit_event/miss_event  performance-counter strobes
// -----------------------------------------------------------------------------
module lc3b_dm_cache_control
  import lc3b_dm_cache_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mem_read,
  input  logic mem_write,
  input  logic hit,
  input  logic victim_dirty,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic cpu_write_en,
  output logic fill_en,
  output logic clean_en,
  output logic hit_event,
  output logic miss_event
);

  localparam logic [1:0] ST_IDLE      = 2'(IDLE);
  localparam logic [1:0] ST_WRITEBACK = 2'(WRITEBACK);
  localparam logic [1:0] ST_FILL      = 2'(FILL);

  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       req;

  assign req = mem_read | mem_write;

  always_comb begin
    state_next   = state_reg;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    cpu_write_en = 1'b0;
    fill_en      = 1'b0;
    clean_en     = 1'b0;
    hit_event    = 1'b0;
    miss_event   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp     = 1'b1;
            // A simultaneous read+write is serviced as a write.
            cpu_write_en = mem_write;
            hit_event    = 1'b1;
          end else begin
            miss_event = 1'b1;
            state_next = victim_dirty ? ST_WRITEBACK : ST_FILL;
          end
        end
      end
      ST_WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          clean_en   = 1'b1;
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_en    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Reset suppresses every side effect of the current cycle; the pmem
    // strobes fall the cycle after because they decode the state register.
    if (reset) begin
      mem_resp     = 1'b0;
      cpu_write_en = 1'b0;
      fill_en      = 1'b0;
      clean_en     = 1'b0;
      hit_event    = 1'b0;
      miss_event   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

endmodule

// File: rtl/lc3b_dm_cache.sv
// -----------------------------------------------------------------------------
// lc3b_dm_cache
// Direct-mapped, write-back, write-allocate cache: 8 sets x one 128-bit line.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mem_address/read/write          CPU request, held until mem_resp
//   mem_byte_enable, mem_wdata      CPU write mask ([1]=high byte) and data
//   mem_rdata, mem_resp             read word and one-cycle completion
//   pmem_address/read/write/wdata   line-granular physical memory request
//   pmem_rdata, pmem_resp           fill data and completion
//   hit_count, miss_count           saturating performance counters
// Build option: define LC3B_CACHE_PERF_EN to implement hit_count/miss_count;
// otherwise both are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module lc3b_dm_cache
  import lc3b_dm_cache_pkg::*;
#(
  parameter int NUM_SETS   = CACHE_SETS,
  parameter int LINE_BYTES = CACHE_LINE_BYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  // Address decomposition
  lc3b_c_offset offset;
  lc3b_c_index  index;
  lc3b_tag      tag;

  assign offset = mem_address[3:1];
  assign index  = mem_address[6:4];
  assign tag    = tag_of(mem_address);

  // Storage: valid/dirty are reset, tags and data are not.
  logic [NUM_SETS-1:0] valid_reg;
  logic [NUM_SETS-1:0] dirty_reg;
  lc3b_tag             tag_array  [NUM_SETS];
  lc3b_line            line_array [NUM_SETS];

  lc3b_tag         stored_tag;
  lc3b_line        stored_line;
  lc3b_line        merged_line;
  lc3b_c_byte_mask byte_mask;
  logic            hit;
  logic            victim_dirty;

  logic cpu_write_en;
  logic fill_en;
  logic clean_en;
  logic hit_event;
  logic miss_event;

  // Read side is combinational so a hit can respond in the request cycle.
  assign stored_tag   = tag_array[index];
  assign stored_line  = line_array[index];
  assign hit          = valid_reg[index] && (stored_tag == tag);
  assign victim_dirty = valid_reg[index] && dirty_reg[index];

  // Byte-granular merge of the CPU write into the addressed line.
  assign byte_mask = expand_wmask(mem_byte_enable, offset);

  generate
    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_merge
      if (gi % 2 == 1) begin : g_hi
        assign merged_line[8*gi +: 8] = byte_mask[gi] ? mem_wdata[15:8]
                                                      : stored_line[8*gi +: 8];
      end else begin : g_lo
        assign merged_line[8*gi +: 8] = byte_mask[gi] ? mem_wdata[7:0]
                                                      : stored_line[8*gi +: 8];
      end
    end
  endgenerate

  lc3b_dm_cache_control u_control (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .hit          (hit),
    .victim_dirty (victim_dirty),
    .pmem_resp    (pmem_resp),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .cpu_write_en (cpu_write_en),
    .fill_en      (fill_en),
    .clean_en     (clean_en),
    .hit_event    (hit_event),
    .miss_event   (miss_event)
  );

  // CPU read data is only driven while a read is being acknowledged.
  assign mem_rdata = (mem_resp && !mem_write) ? stored_line[{offset, 4'b0000} +: 16]
                                              : 16'h0000;

  // Victim goes out at its own address; fills use the requesting line address.
  assign pmem_wdata   = stored_line;
  assign pmem_address = pmem_write ? {stored_tag[8:0], index, 4'b0000} :
                        pmem_read  ? {mem_address[15:4], 4'b0000} :
                                     16'h0000;

  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_array[index] <= pmem_rdata;
      tag_array[index]  <= tag;
    end else if (cpu_write_en) begin
      line_array[index] <= merged_line;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      if (fill_en) begin
        valid_reg[index] <= 1'b1;
        dirty_reg[index] <= 1'b0;
      end
      if (clean_en) begin
        dirty_reg[index] <= 1'b0;
      end
      // An all-zero byte enable still marks the line dirty.
      if (cpu_write_en) begin
        dirty_reg[index] <= 1'b1;
      end
    end
  end

`ifdef LC3B_CACHE_PERF_EN
  logic [15:0] hit_count_reg;
  logic [15:0] miss_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_reg  <= 16'h0000;
      miss_count_reg <= 16'h0000;
    end else begin
      if (hit_event && hit_count_reg != 16'hFFFF) begin
        hit_count_reg <= hit_count_reg + 16'd1;
      end
      if (miss_event && miss_count_reg != 16'hFFFF) begin
        miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

  logic unused_bits;
  assign unused_bits = ^{stored_tag[9], mem_address[0]};
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;

  logic unused_bits;
  assign unused_bits = ^{stored_tag[9], mem_address[0], hit_event, miss_event};
`endif

endmodule

// File: tb/tb_lc3b_dm_cache.sv
// -----------------------------------------------------------------------------
// tb_lc3b_dm_cache
// Self-checking bench for lc3b_dm_cache. Read expectations come from a
// word-level model of CPU-visible memory and are queued when a read is
// issued, then popped when mem_resp arrives. A behavioural physical memory
// responds with a programmable delay and logs every line transfer.
// -----------------------------------------------------------------------------
module tb_lc3b_dm_cache;

  logic         clk;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  lc3b_dm_cache dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
    int           cycles;
  } pmem_txn_t;

  pmem_txn_t    pmem_log [$];
  logic [15:0]  exp_q [$];
  logic [127:0] mem_lines [logic [15:0]];
  logic [15:0]  cpu_words [logic [15:0]];

  int pmem_delay = 1;
  bit pmem_hold  = 1'b0;
  int mutex_viol = 0;
  int resp_cycles = 0;

  // Initial memory image: word i of line la = 0x1111*(i+1) + (la - 0x1230).
  function automatic logic [127:0] line_pattern(input logic [15:0] la);
    logic [127:0] l;
    logic [15:0]  bias;
    logic [15:0]  w;
    bias = la - 16'h1230;
    for (int i = 0; i < 8; i++) begin
      w = 16'h1111 * 16'(i + 1) + bias;
      l[16*i +: 16] = w;
    end
    return l;
  endfunction

  function automatic logic [127:0] line_of(input logic [15:0] la);
    if (mem_lines.exists(la)) return mem_lines[la];
    return line_pattern(la);
  endfunction

  function automatic logic [15:0] cpu_word(input logic [15:0] addr);
    logic [15:0]  wa;
    logic [127:0] l;
    wa = {addr[15:1], 1'b0};
    if (cpu_words.exists(wa)) return cpu_words[wa];
    l = line_pattern({addr[15:4], 4'h0});
    return l[16*addr[3:1] +: 16];
  endfunction

  // Physical memory responder.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end
      if (!pmem_hold && (pmem_read || pmem_write)) begin
        wait_cnt++;
        if (wait_cnt >= pmem_delay) begin
          if (pmem_write) begin
            mem_lines[pmem_address] = pmem_wdata;
            pmem_log.push_back('{1'b1, pmem_address, pmem_wdata, wait_cnt});
          end else begin
            pmem_rdata = line_of(pmem_address);
            pmem_log.push_back('{1'b0, pmem_address, pmem_rdata, wait_cnt});
          end
          pmem_resp = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Protocol monitor.
  always begin
    @(negedge clk);
    #2;
    if (pmem_read && pmem_write) mutex_viol++;
    if (mem_resp) resp_cycles++;
  end

  // One CPU access; lat = negedges waited after the request cycle.
  task automatic cpu_access(input logic [15:0] addr, input bit wr, input logic [1:0] mask,
                            input logic [15:0] wdata, output int lat);
    logic [15:0] old_w;
    logic [15:0] new_w;
    logic [15:0] exp_w;
    @(negedge clk);
    mem_address     = addr;
    mem_read        = !wr;
    mem_write       = wr;
    mem_byte_enable = mask;
    mem_wdata       = wdata;
    if (wr) begin
      old_w = cpu_word(addr);
      new_w = {mask[1] ? wdata[15:8] : old_w[15:8], mask[0] ? wdata[7:0] : old_w[7:0]};
      cpu_words[{addr[15:1], 1'b0}] = new_w;
    end else begin
      exp_q.push_back(cpu_word(addr));
    end
    lat = 0;
    #1;
    while (!mem_resp && lat < 300) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!mem_resp) begin
      check_eq($sformatf("resp_timeout@%h", addr), mem_resp, 1'b1);
      if (!wr) exp_w = exp_q.pop_front();
    end else if (!wr) begin
      exp_w = exp_q.pop_front();
      check_eq($sformatf("rdata@%h", addr), mem_rdata, exp_w);
    end
    $display("txn %s addr=%h mask=%b wdata=%h rdata=%h latency=%0d",
             wr ? "WR" : "RD", addr, mask, wdata, mem_rdata, lat);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  function automatic logic [127:0] cpu_line(input logic [15:0] la);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[16*i +: 16] = cpu_word(la + 16'(2 * i));
    return l;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0;
    int rc0;
    logic [127:0] wb_line;

    reset           = 1'b1;
    mem_address     = 16'h0000;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 2'b00;
    mem_wdata       = 16'h0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("reset_mem_resp", mem_resp, 1'b0);
    check_eq("reset_pmem_read", pmem_read, 1'b0);
    check_eq("reset_pmem_write", pmem_write, 1'b0);
    check_eq("reset_mem_rdata", mem_rdata, 16'h0000);
    check_eq("reset_pmem_address", pmem_address, 16'h0000);

    // 1: cold read, clean miss
    pmem_delay = 1;
    n0 = pmem_log.size();
    cpu_access(16'h1236, 1'b0, 2'b00, 16'h0000, lat);
    check_eq("s1_pmem_txns", pmem_log.size(), n0 + 1);
    check_eq("s1_fill_is_read", pmem_log[n0].wr, 1'b0);
    check_eq("s1_fill_addr", pmem_log[n0].addr, 16'h1230);
    check_eq("s1_latency", lat, 2);

    // 2: byte write hit, then read back
    cpu_access(16'h1236, 1'b1, 2'b01, 16'hBEEF, lat);
    check_eq("s2_write_latency", lat, 0);
    cpu_access(16'h1236, 1'b0, 2'b00, 16'h0000, lat);
    check_eq("s2_read_latency", lat, 0);

    // 3: conflict miss on dirty set 3
    n0 = pmem_log.size();
    wb_line = cpu_line(16'h1230);
    cpu_access(16'h1A36, 1'b0, 2'b00, 16'h0000, lat);
    check_eq("s3_pmem_txns", pmem_log.size(), n0 + 2);
    check_eq("s3_wb_is_write", pmem_log[n0].wr, 1'b1);
    check_eq("s3_wb_addr", pmem_log[n0].addr, 16'h1230);
    check_eq("s3_wb_word3", pmem_log[n0].data[63:48], 16'h44EF);
    check_eq("s3_wb_line", pmem_log[n0].data, wb_line);
    check_eq("s3_fill_is_read", pmem_log[n0+1].wr, 1'b0);
    check_eq("s3_fill_addr", pmem_log[n0+1].addr, 16'h1A30);
    check_eq("s3_latency", lat, 3);

`ifdef LC3B_CACHE_PERF_EN
    check_eq("perf_miss_count", miss_count, 16'd2);
    check_eq("perf_hit_count", hit_count, 16'd4);
`else
    check_eq("perf_miss_count_off", miss_count, 16'd0);
    check_eq("perf_hit_count_off", hit_count, 16'd0);
`endif

    // 4: reset in the middle of a fill
    pmem_hold = 1'b1;
    @(negedge clk);
    mem_address = 16'h2236;
    mem_read    = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("s4_fill_pending", pmem_read, 1'b1);
    reset    = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("s4_pmem_read_after_reset", pmem_read, 1'b0);
    check_eq("s4_pmem_write_after_reset", pmem_write, 1'b0);
    check_eq("s4_pmem_address_after_reset", pmem_address, 16'h0000);
    $display("txn RESET during fill of 2236");
    pmem_hold = 1'b0;
    n0 = pmem_log.size();
    cpu_access(16'h1A36, 1'b0, 2'b00, 16'h0000, lat);
    check_eq("s4_refill_txns", pmem_log.size(), n0 + 1);
    check_eq("s4_refill_addr", pmem_log[n0].addr, 16'h1A30);
    check_eq("s4_latency", lat, 2);
`ifdef LC3B_CACHE_PERF_EN
    check_eq("s4_perf_miss_count", miss_count, 16'd1);
    check_eq("s4_perf_hit_count", hit_count, 16'd1);
`endif

    // 5: slow memory, request held through the fill
    pmem_delay = 5;
    rc0 = resp_cycles;
    n0  = pmem_log.size();
    cpu_access(16'h0000, 1'b0, 2'b00, 16'h0000, lat);
    check_eq("s5_latency", lat, 6);
    check_eq("s5_fill_addr", pmem_log[n0].addr, 16'h0000);
    check_eq("s5_fill_continuous", pmem_log[n0].cycles, 5);
    check_eq("s5_resp_pulses", resp_cycles - rc0, 1);

    check_eq("pmem_mutex", mutex_viol, 0);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
